// File: rtl/fetch_unit.sv
// =============================================================================
// Module      : fetch_unit
// Description : Instruction fetch controller feeding IR and the PC register.
//               Optional fetch timeout enabled by macro FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] PC_STEP = 32'd4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] PC,
    input  logic        redirect_req,
    input  logic [31:0] redirect_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] IR,
    output logic [31:0] next_PC,
    output logic        PC_enable,
    output logic        fetch_done,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_mem_read,   w_mem_read_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0] r_ir,         w_ir_nxt;
    logic [31:0] r_next_pc,    w_next_pc_nxt;
    logic        r_pc_en,      w_pc_en_nxt;
    logic        r_fetch_done, w_fetch_done_nxt;
    logic        r_pend,       w_pend_nxt;
    logic [31:0] r_pend_addr,  w_pend_addr_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_fetch_error, w_fetch_error_nxt;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_mem_read   <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_ir         <= 32'd0;
            r_next_pc    <= 32'd0;
            r_pc_en      <= 1'b0;
            r_fetch_done <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_addr  <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_ir         <= w_ir_nxt;
            r_next_pc    <= w_next_pc_nxt;
            r_pc_en      <= w_pc_en_nxt;
            r_fetch_done <= w_fetch_done_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt         <= '0;
            r_fetch_error <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_fetch_error <= w_fetch_error_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_mem_read_nxt   = r_mem_read;
        w_mem_addr_nxt   = r_mem_addr;
        w_ir_nxt         = r_ir;
        w_next_pc_nxt    = r_next_pc;
        w_pc_en_nxt      = 1'b0;
        w_fetch_done_nxt = 1'b0;
        w_pend_nxt       = r_pend;
        w_pend_addr_nxt  = r_pend_addr;
`ifdef FETCH_TIMEOUT_EN
        w_cnt_nxt         = r_cnt;
        w_fetch_error_nxt = r_fetch_error;
`endif
        case (r_state)
            S_IDLE: begin
                // A redirect in IDLE needs no memory access; any concurrent start is dropped.
                if (redirect_req) begin
                    w_next_pc_nxt = redirect_addr;
                    w_pc_en_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end else if (start) begin
                    w_mem_addr_nxt = {PC[31:2], 2'b00};
                    w_mem_read_nxt = 1'b1;
                    w_state_nxt    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    w_cnt_nxt         = '0;
                    w_fetch_error_nxt = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_ir_nxt         = mem_data;
                    w_mem_read_nxt   = 1'b0;
                    w_pc_en_nxt      = 1'b1;
                    w_fetch_done_nxt = 1'b1;
                    w_state_nxt      = S_DONE;
                    // The freshest redirect wins, including one arriving with the data.
                    if (redirect_req)
                        w_next_pc_nxt = redirect_addr;
                    else if (r_pend)
                        w_next_pc_nxt = r_pend_addr;
                    else
                        w_next_pc_nxt = PC + PC_STEP;
                end else begin
                    if (redirect_req) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = redirect_addr;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_mem_read_nxt    = 1'b0;
                        w_fetch_error_nxt = 1'b1;
                        w_pend_nxt        = 1'b0;
                        w_state_nxt       = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                w_pend_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_read   = r_mem_read;
    assign mem_addr   = r_mem_addr;
    assign IR         = r_ir;
    assign next_PC    = r_next_pc;
    assign PC_enable  = r_pc_en;
    assign fetch_done = r_fetch_done;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error = r_fetch_error;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// =============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] PC;
    logic        redirect_req;
    logic [31:0] redirect_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] IR;
    logic [31:0] next_PC;
    logic        PC_enable;
    logic        fetch_done;
    logic        fetch_error;

    fetch_unit #(
        .PC_STEP (32'd4),
        .TIMEOUT (4)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .start         (start),
        .PC            (PC),
        .redirect_req  (redirect_req),
        .redirect_addr (redirect_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .IR            (IR),
        .next_PC       (next_PC),
        .PC_enable     (PC_enable),
        .fetch_done    (fetch_done),
        .fetch_error   (fetch_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
        logic        done;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          delay;
        int          redir_at;
        logic [31:0] raddr;
        logic [31:0] exp_addr;
        logic [31:0] exp_npc;
    } vec_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] last_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every PC_enable strobe must match the oldest expectation.
    always @(negedge clock) begin
        if (!clear && PC_enable) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pc_enable: got next_PC %h expected no strobe", next_PC);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ir", IR, e.ir);
                chk("sb_next_pc", next_PC, e.npc);
                chk("sb_fetch_done", {31'd0, fetch_done}, {31'd0, e.done});
            end
        end else if (!clear && fetch_done) begin
            chk("done_without_pc_enable", {31'd0, PC_enable}, 32'd1);
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clock);
        PC    = v.pc;
        start = 1'b1;
        e.ir = v.data; e.npc = v.exp_npc; e.done = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        chk("req_mem_read", {31'd0, mem_read}, 32'd1);
        chk("req_mem_addr", mem_addr, v.exp_addr);
        for (int i = 0; i <= v.delay; i++) begin
            redirect_req  = (i == v.redir_at);
            redirect_addr = v.raddr;
            mem_ready     = (i == v.delay);
            mem_data      = v.data;
            @(negedge clock);
        end
        redirect_req = 1'b0;
        mem_ready    = 1'b0;
        @(negedge clock);
        chk("post_pc_enable", {31'd0, PC_enable}, 32'd0);
        chk("post_mem_read", {31'd0, mem_read}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        last_ir = v.data;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   hi;
        vec_t v;

        vecs[0] = '{32'h0000_0010, 32'hA5A5_0001, 3, -1, 32'h0,   32'h0000_0010, 32'h0000_0014};
        vecs[1] = '{32'hFFFF_FFFC, 32'h1234_5678, 0, -1, 32'h0,   32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_0100, 32'hDEAD_BEEF, 2,  0, 32'h200, 32'h0000_0100, 32'h0000_0200};
        vecs[3] = '{32'h0000_0007, 32'h0BAD_F00D, 1, -1, 32'h0,   32'h0000_0004, 32'h0000_000B};
        vecs[4] = '{32'h0000_0040, 32'hCAFE_0004, 0,  0, 32'h300, 32'h0000_0040, 32'h0000_0300};
        vecs[5] = '{32'h8000_0020, 32'h5555_AAAA, 3,  2, 32'h404, 32'h8000_0020, 32'h0000_0404};

        clear = 1'b1; start = 1'b0; PC = 32'd0; redirect_req = 1'b0;
        redirect_addr = 32'd0; mem_ready = 1'b0; mem_data = 32'd0;
        last_ir = 32'd0;
        @(negedge clock);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ir", IR, 32'd0);
        chk("rst_next_pc", next_PC, 32'd0);
        chk("rst_pc_enable", {31'd0, PC_enable}, 32'd0);
        chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
        @(negedge clock);
        clear = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start and redirect together in IDLE: redirect wins, no memory access
        @(negedge clock);
        PC = 32'h0000_0500; start = 1'b1; redirect_req = 1'b1; redirect_addr = 32'h80;
        e.ir = last_ir; e.npc = 32'h80; e.done = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0; redirect_req = 1'b0;
        chk("redir_idle_mem_read", {31'd0, mem_read}, 32'd0);
        @(negedge clock);
        chk("redir_idle_mem_read2", {31'd0, mem_read}, 32'd0);
        chk("redir_idle_drained", sb.size(), 32'd0);

        // two redirects in REQ: the later one overwrites the pending target
        @(negedge clock);
        PC = 32'h60; start = 1'b1;
        e.ir = 32'h1111_2222; e.npc = 32'h500; e.done = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0; redirect_req = 1'b1; redirect_addr = 32'h400;
        @(negedge clock);
        redirect_addr = 32'h500;
        @(negedge clock);
        redirect_req = 1'b0; mem_ready = 1'b1; mem_data = 32'h1111_2222;
        @(negedge clock);
        mem_ready = 1'b0;
        // redirect during DONE must be ignored
        redirect_req = 1'b1; redirect_addr = 32'h900;
        @(negedge clock);
        redirect_req = 1'b0;
        @(negedge clock);
        chk("done_redir_drained", sb.size(), 32'd0);
        last_ir = 32'h1111_2222;
        v = '{32'h24, 32'h3333_4444, 0, -1, 32'h0, 32'h24, 32'h28};
        run_vec(v);

        // no mem_ready: timeout build aborts, default build waits
        @(negedge clock);
        PC = 32'h30; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hi = 0;
        redirect_req = 1'b1; redirect_addr = 32'h700;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            if (mem_read) hi++;
            @(negedge clock);
            redirect_req = 1'b0;
        end
        chk("timeout_req_cycles", hi, 32'd4);
        chk("timeout_mem_read", {31'd0, mem_read}, 32'd0);
        chk("timeout_fetch_error", {31'd0, fetch_error}, 32'd1);
        chk("timeout_drained", sb.size(), 32'd0);
        v = '{32'h34, 32'h7777_0000, 1, -1, 32'h0, 32'h34, 32'h38};
        run_vec(v);
        chk("error_cleared", {31'd0, fetch_error}, 32'd0);
`else
        for (int i = 0; i < 22; i++) begin
            if (mem_read) hi++;
            @(negedge clock);
            redirect_req = 1'b0;
        end
        chk("hold_req_cycles", hi, 32'd22);
        chk("hold_fetch_error", {31'd0, fetch_error}, 32'd0);
        e.ir = 32'h7777_0000; e.npc = 32'h700; e.done = 1'b1;
        sb.push_back(e);
        mem_ready = 1'b1; mem_data = 32'h7777_0000;
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("hold_drained", sb.size(), 32'd0);
        last_ir = 32'h7777_0000;
`endif

        // clear mid-REQ aborts the fetch and zeroes outputs at once
        @(negedge clock);
        PC = 32'h44; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2 clear = 1'b1;
        #1;
        chk("clr_mem_read", {31'd0, mem_read}, 32'd0);
        chk("clr_mem_addr", mem_addr, 32'd0);
        chk("clr_ir", IR, 32'd0);
        chk("clr_next_pc", next_PC, 32'd0);
        chk("clr_pc_enable", {31'd0, PC_enable}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        mem_ready = 1'b1; mem_data = 32'hBBBB_BBBB;
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("clr_idle_mem_read", {31'd0, mem_read}, 32'd0);
        chk("clr_ir_kept", IR, 32'd0);
        last_ir = 32'd0;
        v = '{32'h48, 32'h9999_0001, 2, -1, 32'h0, 32'h48, 32'h4C};
        run_vec(v);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
